serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial two's-complement adder/subtractor built around a single full-adder cell and a registered carry. It accepts two WIDTH-bit operands in parallel and resolves one bit per clock, LSB first. It returns the parallel result with carry-out and signed overflow flags. It is the sequential counterpart to the combinational 1-bit full adder, and is used where area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request new operation; sampled only when busy=0
- sub  input  1  0: a+b, 1: a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed (RUN state)
- done  output  1  one-cycle pulse; result/cout/overflow just updated
- result  output  WIDTH  sum/difference, modulo 2^WIDTH
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE. The state register, operand shift registers, carry flop, bit counter and output registers are all clocked by clk.
- IDLE or DONE, with start=1:
  - load sa=a and sb=(sub ? ~b : b);
  - carry=sub; count=0;
  - go to RUN.
- IDLE, with start=0: stay. DONE, with start=0: go to IDLE.
- RUN, each cycle:
  - s = sa[0]^sb[0]^carry; c = majority(sa[0], sb[0], carry);
  - shift sa and sb right by one;
  - shift s into the MSB of the result shift register;
  - carry<=c; count<=count+1.
- On the RUN cycle with count=WIDTH-1:
  - result <= final shifted value including that cycle's s;
  - cout <= c;
  - overflow <= carry XOR c, where carry is the carry into the MSB;
  - go to DONE.
- start while in RUN: ignored. It is not queued, and operands are not resampled.
- Input changes on a, b, sub during RUN have no effect.
- result, cout and overflow are updated only on completion. They hold their previous values through a following operation until that operation's done.
- Counter width: $clog2(WIDTH+1) bits. WIDTH=1 is legal: a single RUN cycle.
- Arithmetic is pure modulo 2^WIDTH. No saturation.

## Timing
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, result=0, cout=0, overflow=0, and internal carry/count/shift registers cleared. Reset takes priority over start.
- Reset mid-RUN: the operation is abandoned with no done pulse. Outputs are zeroed on that edge.
- Start accepted at edge E0: busy=1 from E0 through E(WIDTH-1). Bit i is processed in the cycle ending at edge E(i+1).
- At edge E(WIDTH): outputs are updated, done=1 and busy=0 for exactly one cycle.
- Latency: done is visible WIDTH cycles after the start-accepting edge. Minimum start-to-start interval is WIDTH+1 cycles, because back-to-back start in DONE is accepted.
- start held high continuously: a new operation starts every WIDTH+1 cycles. Each operation produces exactly one done pulse.
- busy and done are never high in the same cycle.

## Test plan
- Reset, then add with WIDTH=8: a=0x3C, b=0x05, sub=0 -> result=0x41, cout=0, overflow=0.
  - busy high for 8 cycles; done pulse on the 8th edge after start.
  - All outputs are 0 before the first start.
- Carry and overflow cases:
  - 0xFF+0x01 -> result=0x00, cout=1, overflow=0.
  - 0x7F+0x01 -> result=0x80, cout=0, overflow=1.
- Subtract cases:
  - 0x05-0x07 -> result=0xFE, cout=0, overflow=0.
  - 0x80-0x01 -> result=0x7F, cout=1, overflow=1.
  - 0x33-0x33 -> result=0x00, cout=1, overflow=0.
- Busy and back-to-back behaviour:
  - Pulse start with new operands at cycle 3 of a RUN -> ignored; the first result is unaffected.
  - Assert start during done -> accepted; the second op completes 8 cycles later.
  - The previous result holds until the second done.
- Reset mid-operation: assert rst at cycle 4 of RUN -> no done pulse; result/cout/overflow=0 next cycle.
  - A fresh start then completes correctly: 0x10+0x20=0x30.
- WIDTH=1 instance, all four (a,b) combos with sub=0 -> (result,cout) = 00, 10, 10, 01, with done on the first edge after start.
  - Repeat with sub=1: 1-1 -> result=0, cout=1.
  - Randomised 1000-op sweep at WIDTH=8 against a reference model -> no mismatches.

Source files
------------

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial two's-complement adder/subtractor
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first,
//   using a single full-adder cell and a registered carry. Subtraction is
//   a + ~b + 1, with the +1 supplied by presetting the carry.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (priority over start)
//   start     request a new operation, sampled only when busy=0
//   sub       0: a+b, 1: a-b, sampled with start
//   a, b      WIDTH-bit operands, sampled with start
//   busy      high while bits are being processed
//   done      one-cycle pulse, result/cout/overflow just updated
//   result    sum/difference modulo 2^WIDTH
//   cout      carry out of MSB (for subtract, 1 = no borrow)
//   overflow  signed overflow (carry into MSB xor carry out of MSB)

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] shreg;
  logic             carry;
  logic [CW-1:0]    count;

  logic             bit_s;
  logic             bit_c;
  logic             last;
  logic             load;
  logic [WIDTH-1:0] sh_next;

  // Full-adder cell on the current LSBs plus the registered carry.
  always_comb begin
    bit_s   = sa[0] ^ sb[0] ^ carry;
    bit_c   = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    last    = (count == CW'(WIDTH - 1));
    // New sum bit enters at the MSB; written with shifts so WIDTH=1 works.
    sh_next = (shreg >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
  end

  // Next-state logic. A start in DONE is accepted so back-to-back
  // operations run every WIDTH+1 cycles.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end
      end
      S_RUN: begin
        if (last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_next = S_RUN;
          load       = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: operand shifters, carry, counter and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa       <= '0;
      sb       <= '0;
      shreg    <= '0;
      carry    <= 1'b0;
      count    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      sa    <= a;
      sb    <= sub ? ~b : b;
      carry <= sub;
      count <= '0;
    end else if (state == S_RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      shreg <= sh_next;
      carry <= bit_c;
      count <= count + CW'(1);
      if (last) begin
        // carry here is still the carry into the MSB.
        result   <= sh_next;
        cout     <= bit_c;
        overflow <= carry ^ bit_c;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub

module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] res8;
  logic       start1, sub1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] res1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .result(res1), .cout(cout1), .overflow(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one WIDTH=8 op from the next negedge; returns at the negedge of the done cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [7:0] er, input logic ec, input logic eo,
                     input bit check_busy, input string tag);
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (check_busy) begin
        chk({tag, "_busy"}, busy8, 1'b1);
        chk({tag, "_nodone"}, done8, 1'b0);
      end
      @(negedge clk);
    end
    chk({tag, "_done"}, done8, 1'b1);
    chk({tag, "_busy_lo"}, busy8, 1'b0);
    chk({tag, "_res"}, res8, er);
    chk({tag, "_cout"}, cout8, ec);
    chk({tag, "_ovf"}, ovf8, eo);
  endtask

  task automatic op1(input logic a, input logic b, input logic s,
                     input logic er, input logic ec, input logic eo, input string tag);
    @(negedge clk);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk({tag, "_busy"}, busy1, 1'b1);
    @(negedge clk);
    chk({tag, "_done"}, done1, 1'b1);
    chk({tag, "_res"}, res1, er);
    chk({tag, "_cout"}, cout1, ec);
    chk({tag, "_ovf"}, ovf1, eo);
  endtask

  initial begin
    logic [7:0] ra, rb, rr;
    logic       rs, rc, ro;
    logic [8:0] sum;
    bit         saw_done;

    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_res", res8, 8'h00);
    chk("rst_cout", cout8, 1'b0);
    chk("rst_ovf", ovf8, 1'b0);
    chk("rst_res1", res1, 1'b0);

    // Add, carry and overflow, subtract cases
    op8(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1, "add_3c_05");
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1, "add_ff_01");
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1, "add_7f_01");
    op8(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1, "sub_05_07");
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1, "sub_80_01");
    op8(8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1, "sub_33_33");

    // Start pulsed during RUN is ignored and operand changes have no effect
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("ign_done", done8, 1'b1);
    chk("ign_res", res8, 8'h46);
    chk("ign_cout", cout8, 1'b0);
    @(negedge clk);
    chk("ign_no_requeue", busy8, 1'b0);

    // Back-to-back: start asserted in the DONE cycle is accepted
    op8(8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0, 0, "b2b_first");
    a8 = 8'h20; b8 = 8'h01; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_busy", busy8, 1'b1);
      chk("b2b_hold", res8, 8'h11);
      @(negedge clk);
    end
    chk("b2b_done", done8, 1'b1);
    chk("b2b_res", res8, 8'h1F);
    chk("b2b_cout", cout8, 1'b1);

    // Reset mid-operation
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_res", res8, 8'h00);
    chk("mid_rst_cout", cout8, 1'b0);
    chk("mid_rst_ovf", ovf8, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done8) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("mid_rst_no_done", saw_done, 1'b0);
    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1, "after_rst");

    // WIDTH=1 instance
    op1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "w1_add00");
    op1(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "w1_add01");
    op1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "w1_add10");
    op1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "w1_add11");
    op1(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "w1_sub00");
    op1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "w1_sub01");
    op1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "w1_sub10");
    op1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "w1_sub11");

    // Randomised sweep against an arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (rs) begin
        sum = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
        rr  = sum[7:0];
        ro  = (ra[7] != rb[7]) && (rr[7] != ra[7]);
      end else begin
        sum = {1'b0, ra} + {1'b0, rb};
        rr  = sum[7:0];
        ro  = (ra[7] == rb[7]) && (rr[7] != ra[7]);
      end
      rc = sum[8];
      op8(ra, rb, rs, rr, rc, ro, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
